// File: rtl/expr_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : expr_stream_checker
// Description : Serial arithmetic-expression recognizer. Consumes one ASCII
//               character per in_valid cycle and reports whether the
//               characters consumed so far form a complete, well-formed
//               expression. Sticky error flag with capture of the first
//               offending character position.
//
// Ports       : clk      - rising-edge clock
//               clr_n    - synchronous active-low reset
//               start    - synchronous restart pulse (char of that cycle dropped)
//               in_valid - in is consumed this cycle when high
//               in       - 8-bit ASCII character
//               out      - 1 = consumed string is a complete valid expression
//               err      - sticky syntax error
//               err_pos  - 0-based index of the first offending character
//               depth    - current open-parenthesis count
//
// Options     : SPACE_SKIP_EN - when defined, space/tab are consumed as
//               whitespace; whitespace after a number ends it (state NUMD).
//               When undefined, space/tab are illegal characters.
//
// Revision    : 1.0 - initial release
// ============================================================================
module expr_stream_checker #(
    parameter int MAX_DEPTH     = 4,
    parameter int MAX_DIGITS    = 3,
    parameter int ALLOW_SUB_DIV = 0,
    parameter int POS_W         = 8
) (
    input  logic                           clk,
    input  logic                           clr_n,
    input  logic                           start,
    input  logic                           in_valid,
    input  logic [7:0]                     in,
    output logic                           out,
    output logic                           err,
    output logic [POS_W-1:0]               err_pos,
    output logic [$clog2(MAX_DEPTH+1)-1:0] depth
);

    localparam int DW  = $clog2(MAX_DEPTH + 1);
    localparam int DGW = $clog2(MAX_DIGITS + 1);

    localparam logic [DW-1:0]    c_max_depth  = DW'(MAX_DEPTH);
    localparam logic [DGW-1:0]   c_max_digits = DGW'(MAX_DIGITS);
    localparam logic [POS_W-1:0] c_pos_max    = {POS_W{1'b1}};

    localparam logic [2:0] S_EXP  = 3'd0;  // expecting an operand
    localparam logic [2:0] S_NUM  = 3'd1;  // inside a number
    localparam logic [2:0] S_RPAR = 3'd2;  // just closed a parenthesis
    localparam logic [2:0] S_NUMD = 3'd3;  // number terminated by whitespace
    localparam logic [2:0] S_ERR  = 3'd4;  // absorbing error state

    logic [2:0]       r_state,   w_state_nxt;
    logic [DW-1:0]    r_depth,   w_depth_nxt;
    logic [DGW-1:0]   r_dig_cnt, w_dig_cnt_nxt;
    logic [POS_W-1:0] r_pos,     w_pos_nxt;
    logic             r_err,     w_err_nxt;
    logic [POS_W-1:0] r_err_pos, w_err_pos_nxt;
    logic             w_fail;

    // Character classes
    logic w_is_dig, w_is_op, w_is_lp, w_is_rp, w_is_ws;

    always_comb begin
        w_is_dig = (in >= 8'h30) && (in <= 8'h39);
        w_is_op  = (in == 8'h2B) || (in == 8'h2A) ||
                   ((ALLOW_SUB_DIV != 0) && ((in == 8'h2D) || (in == 8'h2F)));
        w_is_lp  = (in == 8'h28);
        w_is_rp  = (in == 8'h29);
`ifdef SPACE_SKIP_EN
        w_is_ws  = (in == 8'h20) || (in == 8'h09);
`else
        w_is_ws  = 1'b0;
`endif
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_depth_nxt   = r_depth;
        w_dig_cnt_nxt = r_dig_cnt;
        w_pos_nxt     = r_pos;
        w_err_nxt     = r_err;
        w_err_pos_nxt = r_err_pos;
        w_fail        = 1'b0;

        if (in_valid) begin
            // Saturating position; err_pos naturally picks up the saturated
            // value for errors at or beyond the counter limit.
            if (r_pos != c_pos_max) begin
                w_pos_nxt = r_pos + POS_W'(1);
            end

            case (r_state)
                S_EXP: begin
                    if (w_is_dig) begin
                        w_state_nxt   = S_NUM;
                        w_dig_cnt_nxt = DGW'(1);
                    end else if (w_is_lp) begin
                        if (r_depth == c_max_depth) w_fail = 1'b1;
                        else                        w_depth_nxt = r_depth + DW'(1);
                    end else if (!w_is_ws) begin
                        w_fail = 1'b1;
                    end
                end
                S_NUM: begin
                    if (w_is_dig) begin
                        if (r_dig_cnt == c_max_digits) w_fail = 1'b1;
                        else                           w_dig_cnt_nxt = r_dig_cnt + DGW'(1);
                    end else if (w_is_op) begin
                        w_state_nxt = S_EXP;
                    end else if (w_is_rp) begin
                        if (r_depth == '0) begin
                            w_fail = 1'b1;
                        end else begin
                            w_state_nxt = S_RPAR;
                            w_depth_nxt = r_depth - DW'(1);
                        end
                    end else if (w_is_ws) begin
                        w_state_nxt = S_NUMD;
                    end else begin
                        w_fail = 1'b1;
                    end
                end
                S_RPAR, S_NUMD: begin
                    if (w_is_op) begin
                        w_state_nxt = S_EXP;
                    end else if (w_is_rp) begin
                        if (r_depth == '0) begin
                            w_fail = 1'b1;
                        end else begin
                            w_state_nxt = S_RPAR;
                            w_depth_nxt = r_depth - DW'(1);
                        end
                    end else if (!w_is_ws) begin
                        w_fail = 1'b1;
                    end
                end
                default: begin
                    // S_ERR absorbs everything until reset or start
                end
            endcase

            // depth and dig_cnt are left untouched on the failing char
            if (w_fail) begin
                w_state_nxt   = S_ERR;
                w_depth_nxt   = r_depth;
                w_dig_cnt_nxt = r_dig_cnt;
                w_err_nxt     = 1'b1;
                w_err_pos_nxt = r_pos;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n || start) begin
            r_state   <= S_EXP;
            r_depth   <= '0;
            r_dig_cnt <= '0;
            r_pos     <= '0;
            r_err     <= 1'b0;
            r_err_pos <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_depth   <= w_depth_nxt;
            r_dig_cnt <= w_dig_cnt_nxt;
            r_pos     <= w_pos_nxt;
            r_err     <= w_err_nxt;
            r_err_pos <= w_err_pos_nxt;
        end
    end

    // Moore output decoded from registered state only
    assign out     = ((r_state == S_NUM) || (r_state == S_NUMD) || (r_state == S_RPAR)) &&
                     (r_depth == '0);
    assign err     = r_err;
    assign err_pos = r_err_pos;
    assign depth   = r_depth;

endmodule
`default_nettype wire

// File: tb/tb_expr_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_expr_stream_checker
// Description : Directed self-checking bench for expr_stream_checker using
//               default parameters (MAX_DEPTH=4, MAX_DIGITS=3,
//               ALLOW_SUB_DIV=0, POS_W=8). Whitespace checks follow the
//               SPACE_SKIP_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_expr_stream_checker;

    logic       clk;
    logic       clr_n;
    logic       start;
    logic       in_valid;
    logic [7:0] in_c;
    logic       out;
    logic       err;
    logic [7:0] err_pos;
    logic [2:0] depth;

    int n_cmp;
    int n_bad;

    expr_stream_checker #(
        .MAX_DEPTH     (4),
        .MAX_DIGITS    (3),
        .ALLOW_SUB_DIV (0),
        .POS_W         (8)
    ) u_dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .in_valid (in_valid),
        .in       (in_c),
        .out      (out),
        .err      (err),
        .err_pos  (err_pos),
        .depth    (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic send_char(input byte c);
        in_valid = 1'b1;
        in_c     = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_c     = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
        n_cmp++; if (out !== 1'b0) begin n_bad++; $display("FAIL reset_out got %0b want 0", out); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0b want 0", err); end
        n_cmp++; if (err_pos !== 8'd0) begin n_bad++; $display("FAIL reset_err_pos got %0d want 0", err_pos); end
        n_cmp++; if (depth !== 3'd0) begin n_bad++; $display("FAIL reset_depth got %0d want 0", depth); end
    endtask

    task automatic test_expression();
        string s;
        string exp_out;
        s       = "12+(3*45)";
        exp_out = "110000001";
        do_start();
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
            n_cmp++;
            if (out !== (exp_out[i] == "1")) begin
                n_bad++;
                $display("FAIL expr_out idx %0d got %0b want %s", i, out, exp_out.substr(i, i));
            end
        end
        n_cmp++; if (depth !== 3'd0) begin n_bad++; $display("FAIL expr_depth got %0d want 0", depth); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL expr_err got %0b want 0", err); end
    endtask

    task automatic test_depth();
        do_start();
        send_str("((((1))))");
        n_cmp++; if (out !== 1'b1) begin n_bad++; $display("FAIL nest4_out got %0b want 1", out); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL nest4_err got %0b want 0", err); end
        do_start();
        send_str("((((");
        n_cmp++; if (depth !== 3'd4) begin n_bad++; $display("FAIL nest_depth4 got %0d want 4", depth); end
        send_str("(1");
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL nest5_err got %0b want 1", err); end
        n_cmp++; if (err_pos !== 8'd4) begin n_bad++; $display("FAIL nest5_err_pos got %0d want 4", err_pos); end
        n_cmp++; if (depth !== 3'd4) begin n_bad++; $display("FAIL nest5_depth got %0d want 4", depth); end
    endtask

    task automatic test_digits();
        do_start();
        send_str("123");
        n_cmp++; if (out !== 1'b1) begin n_bad++; $display("FAIL dig3_out got %0b want 1", out); end
        send_char("4");
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL dig4_err got %0b want 1", err); end
        n_cmp++; if (err_pos !== 8'd3) begin n_bad++; $display("FAIL dig4_err_pos got %0d want 3", err_pos); end
        n_cmp++; if (out !== 1'b0) begin n_bad++; $display("FAIL dig4_out got %0b want 0", out); end
        // Error is absorbing: further chars must not move err_pos
        send_str("+1");
        n_cmp++; if (err_pos !== 8'd3) begin n_bad++; $display("FAIL sticky_err_pos got %0d want 3", err_pos); end
        n_cmp++; if (out !== 1'b0) begin n_bad++; $display("FAIL sticky_out got %0b want 0", out); end
    endtask

    task automatic test_misc();
        do_start();
        send_str("1)");
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rp_under_err got %0b want 1", err); end
        n_cmp++; if (err_pos !== 8'd1) begin n_bad++; $display("FAIL rp_under_err_pos got %0d want 1", err_pos); end
        n_cmp++; if (depth !== 3'd0) begin n_bad++; $display("FAIL rp_under_depth got %0d want 0", depth); end
        do_start();
        send_str("1+");
        n_cmp++; if (out !== 1'b0) begin n_bad++; $display("FAIL trail_op_out got %0b want 0", out); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL trail_op_err got %0b want 0", err); end
        do_start();
        send_str("1-2");
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL sub_err got %0b want 1", err); end
        n_cmp++; if (err_pos !== 8'd1) begin n_bad++; $display("FAIL sub_err_pos got %0d want 1", err_pos); end
        do_start();
        send_str("2*(1)+3");
        n_cmp++; if (out !== 1'b1) begin n_bad++; $display("FAIL rpar_op_out got %0b want 1", out); end
    endtask

    task automatic test_gap_and_start();
        do_start();
        send_str("(1");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (depth !== 3'd1 || out !== 1'b0 || err !== 1'b0) begin
                n_bad++;
                $display("FAIL gap_hold cyc %0d got depth %0d out %0b err %0b want 1 0 0", i, depth, out, err);
            end
        end
        // start with a valid char present: char must be discarded
        in_valid = 1'b1;
        in_c     = ")";
        do_start();
        in_valid = 1'b0;
        n_cmp++; if (out !== 1'b0 || err !== 1'b0 || depth !== 3'd0) begin
            n_bad++; $display("FAIL restart got out %0b err %0b depth %0d want 0 0 0", out, err, depth);
        end
        send_char("7");
        n_cmp++; if (out !== 1'b1) begin n_bad++; $display("FAIL restart_7_out got %0b want 1", out); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out !== 1'b1) begin n_bad++; $display("FAIL idle_out got %0b want 1", out); end
        send_char("x");
        n_cmp++; if (err !== 1'b1 || err_pos !== 8'd1) begin
            n_bad++; $display("FAIL bad_char got err %0b pos %0d want 1 1", err, err_pos);
        end
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL clr_err got %0b want 0", err); end
    endtask

    task automatic test_saturation();
        do_start();
        for (int i = 0; i < 260; i++) send_char((i % 2 == 0) ? "1" : "+");
        n_cmp++; if (err !== 1'b0 || out !== 1'b0) begin
            n_bad++; $display("FAIL long_ok got err %0b out %0b want 0 0", err, out);
        end
        send_char(")");
        n_cmp++; if (err_pos !== 8'd255) begin n_bad++; $display("FAIL sat_err_pos got %0d want 255", err_pos); end
    endtask

    task automatic test_whitespace();
        do_start();
        send_str("1 + 2");
`ifdef SPACE_SKIP_EN
        n_cmp++; if (out !== 1'b1 || err !== 1'b0) begin
            n_bad++; $display("FAIL ws_expr got out %0b err %0b want 1 0", out, err);
        end
        do_start();
        send_str("1 2");
        n_cmp++; if (err !== 1'b1 || err_pos !== 8'd2) begin
            n_bad++; $display("FAIL ws_split got err %0b pos %0d want 1 2", err, err_pos);
        end
`else
        n_cmp++; if (err !== 1'b1 || err_pos !== 8'd1) begin
            n_bad++; $display("FAIL ws_bad got err %0b pos %0d want 1 1", err, err_pos);
        end
`endif
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        clr_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_c     = 8'h00;
        test_reset();
        test_expression();
        test_depth();
        test_digits();
        test_misc();
        test_gap_and_start();
        test_saturation();
        test_whitespace();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
